dpll_bitsync: RTL

- Parametrised all-digital PLL bit synchroniser that recovers the bit clock and the retimed data from an asynchronous NRZ/DPSK-demodulated stream.
- Combines, in one block:
  - input synchroniser and edge detector
  - sign phase detector
  - random-walk (K-counter) loop filter
  - add/skip DCO phase accumulator
  - data sampler
  - lock detector
- Sits after the demodulator slicer; feeds the frame/decoder logic.

---
 rtl/dpll_pkg.sv | 32 +++
 rtl/dpll_bitsync_rw_filter.sv | 62 ++++++
 rtl/dpll_bitsync.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dpll_pkg.sv
// Shared definitions for the DPLL bit synchroniser: width helpers and the
// phase-detector vote encoding passed to the random-walk filter.
package dpll_pkg;

  // Phase detector decision handed to the loop filter on each data edge.
  typedef enum logic [1:0] {
    VOTE_NONE = 2'b00,
    VOTE_ADV  = 2'b01,
    VOTE_RET  = 2'b10
  } vote_e;

  // Signed width of the random-walk counter; covers thresholds up to 255.
  localparam int FILT_W = 9;

  // Ceiling log2 usable in constant expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // Number of bits needed to hold a DCO phase 0..div_n-1.
  function automatic int phase_width(input int div_n);
    return clog2(div_n);
  endfunction

endpackage

// File: rtl/dpll_bitsync_rw_filter.sv
// Random-walk (K-counter) loop filter: integrates phase-detector votes and
// emits a single-cycle carry or borrow when the count reaches +/-K.
module rw_filter
  import dpll_pkg::*;
#(
  parameter int K = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] vote,
  input  logic       freeze,
  output logic       carry,
  output logic       borrow
);

  // Reaching +/-K is detected one step early so the counter never holds K.
  localparam logic signed [FILT_W-1:0] K_TOP = FILT_W'(K - 1);
  localparam logic signed [FILT_W-1:0] K_BOT = FILT_W'(1 - K);

  logic signed [FILT_W-1:0] f_r;
  logic                     carry_r;
  logic                     borrow_r;

  // Count votes; a threshold hit clears the count and pulses carry or borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_r      <= 9'sd0;
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
    end else begin
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
      if (freeze) begin
        f_r <= f_r;
      end else begin
        case (vote)
          VOTE_ADV: begin
            if (f_r == K_TOP) begin
              f_r     <= 9'sd0;
              carry_r <= 1'b1;
            end else begin
              f_r <= f_r + 9'sd1;
            end
          end
          VOTE_RET: begin
            if (f_r == K_BOT) begin
              f_r      <= 9'sd0;
              borrow_r <= 1'b1;
            end else begin
              f_r <= f_r - 9'sd1;
            end
          end
          default: f_r <= f_r;
        endcase
      end
    end
  end

  assign carry  = carry_r;
  assign borrow = borrow_r;

endmodule

// File: rtl/dpll_bitsync.sv
// All-digital PLL bit synchroniser: synchronises the incoming NRZ stream,
// compares data edges against an add/skip DCO phase, steers the DCO through
// a random-walk filter, retimes data at bit centre and reports lock.
module dpll_bitsync
  import dpll_pkg::*;
#(
  parameter int DIV_N    = 64,
  parameter int K        = 8,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic                  clk_12,
  input  logic                  rst_n_i,
  input  logic                  data_i,
  input  logic                  freeze_i,
  output logic                  syn_o,
  output logic                  bit_o,
  output logic                  bit_vld_o,
  output logic                  lock_o,
  output logic                  carry_o,
  output logic                  borrow_o,
  output logic [clog2(DIV_N):0] perr_o
);

  localparam int PW = phase_width(DIV_N);
  localparam int CW = clog2(LOCK_CNT + 1);
  localparam logic [PW:0]   DIV_W   = (PW + 1)'(DIV_N);
  localparam logic [PW-1:0] HALF    = PW'(DIV_N / 2);
  localparam logic [PW:0]   TOL_W   = (PW + 1)'(LOCK_TOL);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_CNT);

  logic          sync1_r;
  logic          sync2_r;
  logic          dly_r;
  logic          edge_s;
  logic [PW-1:0] ph_r;
  logic [PW:0]   ph_sum_s;
  logic [PW-1:0] ph_nxt_s;
  logic [PW:0]   perr_s;
  logic [PW:0]   perr_mag_s;
  logic [PW:0]   perr_r;
  logic          in_tol_s;
  vote_e         vote_s;
  logic [1:0]    vote_edge_s;
  logic          carry_s;
  logic          borrow_s;
  logic          cross_s;
  logic          syn_r;
  logic          bit_r;
  logic          bit_vld_r;
  logic          lock_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchroniser plus a delay flop for edge detection.
  always_ff @(posedge clk_12 or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      dly_r   <= 1'b0;
    end else begin
      sync1_r <= data_i;
      sync2_r <= sync1_r;
      dly_r   <= sync2_r;
    end
  end

  assign edge_s = sync2_r ^ dly_r;

  // DCO step: +2 after a carry, hold after a borrow, otherwise +1, mod DIV_N.
  always_comb begin
    ph_sum_s = {1'b0, ph_r};
    if (carry_s) begin
      ph_sum_s = {1'b0, ph_r} + (PW + 1)'(2);
    end else if (borrow_s) begin
      ph_sum_s = {1'b0, ph_r};
    end else begin
      ph_sum_s = {1'b0, ph_r} + (PW + 1)'(1);
    end
    if (ph_sum_s >= DIV_W) begin
      ph_nxt_s = PW'(ph_sum_s - DIV_W);
    end else begin
      ph_nxt_s = ph_sum_s[PW-1:0];
    end
  end

  // Sign phase detector: first half of the cycle means the DCO is early.
  always_comb begin
    perr_s = {(PW + 1){1'b0}};
    vote_s = VOTE_NONE;
    if (ph_r == {PW{1'b0}}) begin
      perr_s = {(PW + 1){1'b0}};
      vote_s = VOTE_NONE;
    end else if (ph_r < HALF) begin
      perr_s = {1'b0, ph_r};
      vote_s = VOTE_RET;
    end else begin
      perr_s = {1'b0, ph_r} - DIV_W;
      vote_s = VOTE_ADV;
    end
  end

  assign vote_edge_s = edge_s ? vote_s : VOTE_NONE;
  assign perr_mag_s  = perr_s[PW] ? (~perr_s + (PW + 1)'(1)) : perr_s;
  assign in_tol_s    = (perr_mag_s <= TOL_W);

  // Bit-centre crossing; a wrap can never satisfy both halves of the test.
  assign cross_s = (ph_r < HALF) && (ph_nxt_s >= HALF);

  rw_filter #(
    .K(K)
  ) u_rw_filter (
    .clk    (clk_12),
    .rst_n  (rst_n_i),
    .vote   (vote_edge_s),
    .freeze (freeze_i),
    .carry  (carry_s),
    .borrow (borrow_s)
  );

  // Advance the DCO phase and register the recovered bit clock from it.
  always_ff @(posedge clk_12 or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ph_r  <= {PW{1'b0}};
      syn_r <= 1'b1;
    end else begin
      ph_r  <= ph_nxt_s;
      syn_r <= (ph_nxt_s < HALF);
    end
  end

  // Capture the phase error at each data edge and hold it between edges.
  always_ff @(posedge clk_12 or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perr_r <= {(PW + 1){1'b0}};
    end else if (edge_s) begin
      perr_r <= perr_s;
    end else begin
      perr_r <= perr_r;
    end
  end

  // Retime synchronised data on the bit-centre crossing and strobe it.
  always_ff @(posedge clk_12 or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_r     <= 1'b0;
      bit_vld_r <= 1'b0;
    end else begin
      bit_vld_r <= cross_s;
      if (cross_s) begin
        bit_r <= sync2_r;
      end else begin
        bit_r <= bit_r;
      end
    end
  end

  // Count consecutive in-tolerance edges; one bad edge drops lock at once.
  always_ff @(posedge clk_12 or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r  <= {CW{1'b0}};
      lock_r <= 1'b0;
    end else if (edge_s) begin
      if (in_tol_s) begin
        if (cnt_r != CNT_MAX) begin
          cnt_r <= cnt_r + CW'(1);
        end else begin
          cnt_r <= cnt_r;
        end
        if (cnt_r >= CNT_MAX - CW'(1)) begin
          lock_r <= 1'b1;
        end else begin
          lock_r <= lock_r;
        end
      end else begin
        cnt_r  <= {CW{1'b0}};
        lock_r <= 1'b0;
      end
    end else begin
      cnt_r  <= cnt_r;
      lock_r <= lock_r;
    end
  end

  assign syn_o     = syn_r;
  assign bit_o     = bit_r;
  assign bit_vld_o = bit_vld_r;
  assign lock_o    = lock_r;
  assign carry_o   = carry_s;
  assign borrow_o  = borrow_s;
  assign perr_o    = perr_r;

endmodule
